// File: rtl/alu_seq.sv
// Command sequencer feeding a combinational 4-bit ALU: register file, sticky flags,
// and a valid/ready response channel with backpressure. One command in flight at a time.
module alu_seq #(
  parameter int unsigned DW  = 4,
  parameter int unsigned RAW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_cmd,
  input  logic [2:0]     in_op,
  input  logic [RAW-1:0] in_rd,
  input  logic [RAW-1:0] in_rs1,
  input  logic [RAW-1:0] in_rs2,
  input  logic [DW-1:0]  in_imm,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [2:0]     alu_op,
  input  logic [DW-1:0]  alu_result,
  input  logic           alu_zero,
  input  logic           alu_carry,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic           out_zero,
  output logic           out_carry,
  output logic           flag_z,
  output logic           flag_c
);

  localparam int unsigned NumRegs = 1 << RAW;

  localparam logic [1:0] CmdAlu   = 2'b00;
  localparam logic [1:0] CmdLoadi = 2'b01;
  localparam logic [1:0] CmdRead  = 2'b10;
  localparam logic [1:0] CmdNop   = 2'b11;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state;
  logic [1:0]       cmd_q;
  logic [RAW-1:0]   rd_q;
  logic [DW-1:0]    imm_q;
  logic [DW-1:0]    rf [NumRegs];

  assign in_ready = (state == StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      cmd_q     <= CmdNop;
      rd_q      <= '0;
      imm_q     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b0;
      out_carry <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      for (int i = 0; i < NumRegs; i++) rf[i] <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            // Operands are fetched for every command; READ reuses alu_a as its source.
            cmd_q  <= in_cmd;
            rd_q   <= in_rd;
            imm_q  <= in_imm;
            alu_a  <= rf[in_rs1];
            alu_b  <= rf[in_rs2];
            alu_op <= in_op;
            state  <= StExec;
          end
        end
        StExec: begin
          unique case (cmd_q)
            CmdAlu: begin
              rf[rd_q]  <= alu_result;
              flag_z    <= alu_zero;
              flag_c    <= alu_carry;
              out_data  <= alu_result;
              out_zero  <= alu_zero;
              out_carry <= alu_carry;
            end
            CmdLoadi: begin
              rf[rd_q]  <= imm_q;
              flag_z    <= (imm_q == '0);
              flag_c    <= 1'b0;
              out_data  <= imm_q;
              out_zero  <= (imm_q == '0);
              out_carry <= 1'b0;
            end
            CmdRead: begin
              out_data  <= alu_a;
              out_zero  <= (alu_a == '0);
              out_carry <= 1'b0;
            end
            CmdNop: begin
              out_data  <= '0;
              out_zero  <= 1'b1;
              out_carry <= 1'b0;
            end
          endcase
          out_valid <= 1'b1;
          state     <= StResp;
        end
        StResp: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
